state_trace_tx: RTL and testbench



---
 rtl/state_trace_tx.sv | 165 ++++++++++++++++
 tb/tb_state_trace_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/state_trace_tx.sv
// Architectural-state dump transmitter: on an accepted snapshot it streams the PC
// followed by x0..x(NREG-1), fetched one register per FETCH cycle, over valid/ready.
module state_trace_tx #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              snap_i,
    input  logic [DATA_W-1:0] pc_i,
    output logic [IDX_W-1:0]  rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic [5:0]        tx_tag_o,
    output logic              tx_last_o,
    output logic              busy_o,
    output logic [15:0]       frame_cnt_o,
    output logic [15:0]       drop_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_PC  = 2'd1,
        ST_FETCH    = 2'd2,
        ST_SEND_REG = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic [5:0]          tx_tag_q, tx_tag_d;
    logic                tx_last_q, tx_last_d;
    logic                busy_q, busy_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic                req_s;
    logic                hs_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    assign req_s = snap_i & start_i;
    assign hs_s  = tx_valid_q & tx_ready_i;

    // Next-state and output-register logic; every field holds unless a transition updates it.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        tx_tag_d    = tx_tag_q;
        tx_last_d   = tx_last_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    tx_data_d   = pc_i;
                    tx_tag_d    = 6'd0;
                    tx_last_d   = 1'b0;
                    tx_valid_d  = 1'b1;
                    busy_d      = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_SEND_PC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND_PC: begin
                if (hs_s) begin
                    tx_valid_d = 1'b0;
                    idx_d      = {IDX_W{1'b0}};
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_SEND_PC;
                end
            end
            ST_FETCH: begin
                // rf_addr_o has been stable for a full cycle, so rf_data_i is valid here
                tx_data_d  = rf_data_i;
                tx_tag_d   = 6'(idx_q) + 6'd1;
                tx_last_d  = (idx_q == IDX_W'(NREG - 1));
                tx_valid_d = 1'b1;
                state_d    = ST_SEND_REG;
            end
            ST_SEND_REG: begin
                if (hs_s) begin
                    tx_valid_d = 1'b0;
                    if (tx_last_q) begin
                        tx_last_d = 1'b0;
                        busy_d    = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND_REG;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_last_d  = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Requests arriving while a frame is in flight are counted, never queued.
    always_comb begin
        if ((state_q != ST_IDLE) && req_s) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            tx_valid_q  <= 1'b0;
            tx_data_q   <= {DATA_W{1'b0}};
            tx_tag_q    <= 6'd0;
            tx_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            tx_tag_q    <= tx_tag_d;
            tx_last_q   <= tx_last_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign rf_addr_o   = idx_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign tx_tag_o    = tx_tag_q;
    assign tx_last_o   = tx_last_q;
    assign busy_o      = busy_q;
    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_state_trace_tx.sv
// Directed bench for state_trace_tx: register file model holds xk = 3*k, frames are
// checked word by word against hand-derived tags, data, timing and counters.
module tb_state_trace_tx;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        snap_i;
    logic [31:0] pc_i;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] tx_data_o;
    logic [5:0]  tx_tag_o;
    logic        tx_last_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    logic [15:0] drop_cnt_o;

    logic [31:0] rf_mem [32];
    int          n_checks;
    int          n_fail;
    logic [15:0] exp_frames;
    logic [15:0] exp_drops;

    state_trace_tx #(.DATA_W(32), .NREG(32), .IDX_W(5)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .snap_i     (snap_i),
        .pc_i       (pc_i),
        .rf_addr_o  (rf_addr_o),
        .rf_data_i  (rf_data_i),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_tag_o   (tx_tag_o),
        .tx_last_o  (tx_last_o),
        .busy_o     (busy_o),
        .frame_cnt_o(frame_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rf_data_i = rf_mem[rf_addr_o];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one frame starting from a negedge. mode 0 = ready always high, 1 = ready 1-of-3.
    // d1..d3: relative cycles with an extra snap; stop_at: drop start_i; rst_at: reset pulse.
    task automatic stream_frame(input logic [31:0] pc, input int mode, input int d1,
                                input int d2, input int d3, input int stop_at, input int rst_at);
        int          w;
        bit          done;
        logic        pv, pr, pl;
        logic [31:0] pd, exp_d;
        logic [5:0]  pt;
        w = 0; done = 1'b0; pv = 1'b0; pr = 1'b1; pd = 32'd0; pt = 6'd0; pl = 1'b0;
        pc_i   = pc;
        snap_i = 1'b1;
        exp_frames = exp_frames + 16'd1;
        for (int rel = 1; rel <= 400 && !done; rel++) begin
            @(negedge clk);
            snap_i = (rel == d1) || (rel == d2) || (rel == d3);
            if (snap_i && start_i)
                exp_drops = (exp_drops == 16'hFFFF) ? exp_drops : exp_drops + 16'd1;
            if (rel == stop_at) start_i = 1'b0;
            if (rel == 1 && rst_at != 1) begin
                check_eq("accept_valid", {31'd0, tx_valid_o}, 32'd1);
                check_eq("accept_busy", {31'd0, busy_o}, 32'd1);
                check_eq("accept_frames", {16'd0, frame_cnt_o}, {16'd0, exp_frames});
            end
            if (rst_at > 0 && rel == rst_at + 1) begin
                check_eq("rst_valid", {31'd0, tx_valid_o}, 32'd0);
                check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
                check_eq("rst_last", {31'd0, tx_last_o}, 32'd0);
                check_eq("rst_frames", {16'd0, frame_cnt_o}, 32'd0);
                check_eq("rst_drops", {16'd0, drop_cnt_o}, 32'd0);
                rst_i = 1'b0;
                snap_i = 1'b0;
                exp_frames = 16'd0;
                exp_drops  = 16'd0;
                done = 1'b1;
            end else if (w == 33) begin
                check_eq("end_busy", {31'd0, busy_o}, 32'd0);
                check_eq("end_valid", {31'd0, tx_valid_o}, 32'd0);
                check_eq("end_frames", {16'd0, frame_cnt_o}, {16'd0, exp_frames});
                check_eq("end_drops", {16'd0, drop_cnt_o}, {16'd0, exp_drops});
                if (mode == 0) check_eq("idle_cycle", rel, 32'd66);
                done = 1'b1;
            end else begin
                if (rel == rst_at) rst_i = 1'b1;
                if (pv && !pr) begin
                    check_eq("stall_data", tx_data_o, pd);
                    check_eq("stall_tag", {26'd0, tx_tag_o}, {26'd0, pt});
                    check_eq("stall_last", {31'd0, tx_last_o}, {31'd0, pl});
                    check_eq("stall_valid", {31'd0, tx_valid_o}, 32'd1);
                end
                tx_ready_i = (mode == 0) ? 1'b1 : ((rel % 3) == 0);
                if (tx_valid_o && tx_ready_i && rel != rst_at) begin
                    exp_d = (w == 0) ? pc : rf_mem[w-1];
                    check_eq("word_tag", {26'd0, tx_tag_o}, w);
                    check_eq("word_data", tx_data_o, exp_d);
                    check_eq("word_last", {31'd0, tx_last_o}, {31'd0, (w == 32)});
                    if (mode == 0) check_eq("word_cycle", rel, 1 + 2 * w);
                    w = w + 1;
                end
            end
            pv = tx_valid_o; pr = tx_ready_i; pd = tx_data_o; pt = tx_tag_o; pl = tx_last_o;
        end
        if (!done) check_eq("frame_timeout", 32'd0, 32'd1);
        snap_i = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        exp_frames = 16'd0; exp_drops = 16'd0;
        for (int k = 0; k < 32; k++) rf_mem[k] = 32'(k * 3);
        rst_i = 1'b1; start_i = 1'b0; snap_i = 1'b0; pc_i = 32'd0; tx_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_valid", {31'd0, tx_valid_o}, 32'd0);
        check_eq("reset_data", tx_data_o, 32'd0);
        check_eq("reset_tag", {26'd0, tx_tag_o}, 32'd0);
        check_eq("reset_last", {31'd0, tx_last_o}, 32'd0);
        check_eq("reset_addr", {27'd0, rf_addr_o}, 32'd0);
        check_eq("reset_busy", {31'd0, busy_o}, 32'd0);
        check_eq("reset_frames", {16'd0, frame_cnt_o}, 32'd0);
        check_eq("reset_drops", {16'd0, drop_cnt_o}, 32'd0);
        rst_i = 1'b0;

        // snaps while disabled are ignored entirely
        for (int i = 0; i < 6; i++) begin
            snap_i = 1'b1;
            @(negedge clk);
            check_eq("disabled_valid", {31'd0, tx_valid_o}, 32'd0);
        end
        snap_i = 1'b0;
        check_eq("disabled_frames", {16'd0, frame_cnt_o}, 32'd0);
        check_eq("disabled_drops", {16'd0, drop_cnt_o}, 32'd0);

        start_i = 1'b1;
        stream_frame(32'h40, 0, -1, -1, -1, -1, -1);
        stream_frame(32'h40, 1, -1, -1, -1, -1, -1);
        stream_frame(32'h1234, 0, 10, 20, -1, -1, -1);
        stream_frame(32'h88, 0, -1, -1, -1, -1, -1);
        stream_frame(32'hCAFE0000, 0, -1, -1, -1, 5, -1);
        start_i = 1'b1;
        stream_frame(32'h40, 0, -1, -1, -1, -1, 30);
        stream_frame(32'h500, 0, -1, -1, -1, -1, -1);

        // saturation of the drop counter
        force dut.drop_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.drop_cnt_q;
        exp_drops = 16'hFFFE;
        @(negedge clk);
        check_eq("forced_drops", {16'd0, drop_cnt_o}, 32'h0000FFFE);
        stream_frame(32'h77, 0, 10, 20, 30, -1, -1);
        check_eq("sat_drops", {16'd0, drop_cnt_o}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
